// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared widths and M-extension funct3 encodings
package muldiv_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] FUNCT3_ALU_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_ALU_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_ALU_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_ALU_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_ALU_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_ALU_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_ALU_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_ALU_REMU   = 3'b111;

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Bit 2 of funct3 separates the divide/remainder group from the multiplies
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/response bundle between core control and the mul/div sequencer
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic            start;
  logic            abort;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, abort, funct3, operand_a, operand_b,
                  input  busy, done, result);
  modport slave  (input  start, abort, funct3, operand_a, operand_b,
                  output busy, done, result);

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 iteration (shift-add multiply or restoring divide)
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic              mode_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]     sum;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] shifted;

  // Multiply: acc = {product_hi, multiplier}; divide: acc = {remainder, quotient}
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = acc << 1;
    // The remainder bit shifted out the top is kept as the 33rd bit of the trial subtract
    diff     = {acc[2*XLEN-1], shifted[2*XLEN-1:XLEN]} - {1'b0, opnd};
    acc_next = {sum, acc[XLEN-1:1]};
    if (mode_div) begin
      if (diff[XLEN]) acc_next = shifted;
      else            acc_next = {diff[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide controller with sign fix-up
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state;
  logic [2:0]        op;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [CNT_W-1:0]  count;

  logic              signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_val;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, final_val;

  muldiv_step u_step (
    .mode_div (is_div_op(op)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // Decode the incoming request: operand magnitudes and the two no-iteration cases
  always_comb begin
    signed_a = bus.funct3 inside {FUNCT3_ALU_MULH, FUNCT3_ALU_MULHSU, FUNCT3_ALU_DIV, FUNCT3_ALU_REM};
    signed_b = bus.funct3 inside {FUNCT3_ALU_MULH, FUNCT3_ALU_DIV, FUNCT3_ALU_REM};
    neg_a    = signed_a && bus.operand_a[XLEN-1];
    neg_b    = signed_b && bus.operand_b[XLEN-1];
    abs_a    = neg_a ? -bus.operand_a : bus.operand_a;
    abs_b    = neg_b ? -bus.operand_b : bus.operand_b;
    div_zero = is_div_op(bus.funct3) && (bus.operand_b == '0);
    div_ovf  = (bus.funct3 inside {FUNCT3_ALU_DIV, FUNCT3_ALU_REM}) &&
               (bus.operand_a == XLEN_MIN) && (bus.operand_b == '1);
    // funct3[1] selects remainder within the divide group
    if (div_zero) special_val = bus.funct3[1] ? bus.operand_a : '1;
    else          special_val = bus.funct3[1] ? '0 : XLEN_MIN;
  end

  // Sign fix-up of the raw magnitude result and selection of the returned word
  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      FUNCT3_ALU_MUL:                    final_val = prod[XLEN-1:0];
      FUNCT3_ALU_DIV, FUNCT3_ALU_DIVU:   final_val = quot;
      FUNCT3_ALU_REM, FUNCT3_ALU_REMU:   final_val = rem;
      default:                           final_val = prod[2*XLEN-1:XLEN];
    endcase
  end

  // Control FSM with registered busy/done/result; abort beats start and any in-flight op
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      count      <= '0;
      acc        <= '0;
      opnd       <= '0;
      op         <= FUNCT3_ALU_MUL;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.abort && state != IDLE) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        count    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              op       <= bus.funct3;
              neg_res  <= neg_a ^ neg_b;
              neg_rem  <= neg_a;
              count    <= '0;
              bus.busy <= 1'b1;
              if (div_zero || div_ovf) begin
                acc        <= '0;
                bus.result <= special_val;
                bus.done   <= 1'b1;
                state      <= DONE;
              end else begin
                acc   <= {{XLEN{1'b0}}, is_div_op(bus.funct3) ? abs_a : abs_b};
                opnd  <= is_div_op(bus.funct3) ? abs_b : abs_a;
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc <= acc_next;
            if (count == CNT_LAST) begin
              count <= '0;
              state <= SIGN;
            end else begin
              count <= count + 1'b1;
            end
          end
          SIGN: begin
            bus.result <= final_val;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
          default: begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer against an arithmetic reference
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          st;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   prev_done = 1'b0;
  logic [31:0] last_res = '0;
  exp_t sb[$];

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / integer arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb_, ub;
    longint unsigned ua, uu;
    longint          p;
    int              ia, ib;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = longint'({32'h0, b});
    ia  = a;
    ib  = b;
    case (f3)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin uu = ua * longint'(unsigned'(ub)); return uu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (prev_done) check("busy_after_done", {31'b0, bus.busy}, 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, bus.result, e.res);
          check({e.name, "_latency"}, 32'(cyc - e.st), 32'(e.lat));
          check({e.name, "_busy_at_done"}, {31'b0, bus.busy}, 32'd1);
        end
      end
    end
    prev_done = bus.done;
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    @(posedge clock); #1;
    bus.funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    e.res  = ref_op(f3, a, b);
    e.lat  = ref_lat(f3, a, b);
    e.st   = cyc;
    e.name = name;
    sb.push_back(e);
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 60 cycles, required done", name);
      sb.delete();
    end
    last_res = e.res;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.funct3 = 3'd0;
    bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    reset = 1'b0;

    issue(FUNCT3_ALU_MUL,    32'd7,          32'd6,          "mul_7x6");
    issue(FUNCT3_ALU_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   "mulh_m1");
    issue(FUNCT3_ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   "mulhu_max");
    issue(FUNCT3_ALU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   "mulhsu_m1");
    issue(FUNCT3_ALU_DIV,    32'hFFFFFFF9,   32'd2,          "div_m7_2");
    issue(FUNCT3_ALU_REM,    32'hFFFFFFF9,   32'd2,          "rem_m7_2");
    issue(FUNCT3_ALU_DIVU,   32'd100,        32'd0,          "divu_by0");
    issue(FUNCT3_ALU_REMU,   32'd100,        32'd0,          "remu_by0");
    issue(FUNCT3_ALU_REM,    32'h80000000,   32'hFFFFFFFF,   "rem_ovf");
    issue(FUNCT3_ALU_DIV,    32'h80000000,   32'hFFFFFFFF,   "div_ovf");
    issue(FUNCT3_ALU_DIVU,   32'hFFFFFFFF,   32'd1,          "divu_max");

    // Abort at cycle 10 with an ignored start at cycle 5
    @(posedge clock); #1;
    bus.funct3 = FUNCT3_ALU_MUL; bus.operand_a = $urandom; bus.operand_b = $urandom;
    bus.start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clock); #1;
      bus.start  = (c == 5);
      bus.abort  = (c == 10);
      if (c == 5) bus.funct3 = FUNCT3_ALU_DIVU;
    end
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_result_held", bus.result, last_res);
    repeat (40) @(posedge clock);

    // Reset at cycle 20 of a DIVU
    #1;
    bus.funct3 = FUNCT3_ALU_DIVU; bus.operand_a = $urandom; bus.operand_b = 32'd3;
    bus.start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      reset     = (c == 20);
    end
    check("midreset_busy", {31'b0, bus.busy}, 32'd0);
    check("midreset_done", {31'b0, bus.done}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    last_res = '0;
    repeat (40) @(posedge clock);

    issue(FUNCT3_ALU_MUL, 32'd3, 32'd5, "mul_3x5_after_reset");

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(f3, a, b, $sformatf("rand%0d_f%0d", n, f3));
    end

    repeat (5) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
